// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a time-division word stream.
// Collects one word per channel slot (slot 0 flagged by in_sync) into a shadow
// register set. It then publishes the whole frame at once on out_data, with a
// one-cycle out_valid pulse. Framing violations give a one-cycle frame_err
// pulse and the block resynchronises.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data / in_sync valid this cycle
//   in_sync    marks the slot-0 word of a frame (qualified by in_valid)
//   in_data    channel word
//   out_data   last complete frame, channel k at [k*WIDTH +: WIDTH]
//   out_valid  one-cycle pulse when out_data updates
//   frame_err  one-cycle pulse on a framing violation
//   locked     1 while in LOCKED state (FSM state observation)
//   slot       next expected slot index
//
// Handshake: a word is consumed on every rising edge where in_valid is 1.
// There is no back-pressure. in_sync and in_data are ignored when in_valid is 0.
module tdm_demux #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 8,
  localparam int SW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_sync,
  input  logic [WIDTH-1:0]          in_data,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic                      frame_err,
  output logic                      locked,
  output logic [SW-1:0]             slot
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [SW-1:0]               r_slot;
  logic [SW-1:0]               w_slot_nxt;
  // The last slot never needs shadowing. It goes straight from in_data into out_data.
  logic [WIDTH-1:0]            r_shadow [CHANNELS-1];
  logic [CHANNELS*WIDTH-1:0]   r_out_data;
  logic                        r_out_valid;
  logic                        r_frame_err;

  logic                        w_shadow_we;
  logic [SW-1:0]               w_shadow_idx;
  logic                        w_load;
  logic                        w_err;
  logic [CHANNELS*WIDTH-1:0]   w_frame;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_HUNT;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (in_valid) begin
      case (r_state)
        ST_HUNT:   if (in_sync) w_state_nxt = ST_LOCKED;
        ST_LOCKED: if (!in_sync && r_slot == '0) w_state_nxt = ST_HUNT;
        default:   w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // Output / datapath decode
  always_comb begin
    w_shadow_we  = 1'b0;
    w_shadow_idx = '0;
    w_slot_nxt   = r_slot;
    w_load       = 1'b0;
    w_err        = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (in_sync) begin
            w_shadow_we = 1'b1;
            w_slot_nxt  = SW'(1);
          end
        end
        ST_LOCKED: begin
          if (in_sync) begin
            // A sync at slot 0 starts a frame normally.
            // A sync anywhere else is early: drop the partial frame and restart on this word.
            w_shadow_we = 1'b1;
            w_slot_nxt  = SW'(1);
            w_err       = (r_slot != '0);
          end else if (r_slot == '0) begin
            // A word at slot 0 without sync means framing is lost.
            w_err = 1'b1;
          end else if (r_slot == LAST_SLOT) begin
            w_load     = 1'b1;
            w_slot_nxt = '0;
          end else begin
            w_shadow_we  = 1'b1;
            w_shadow_idx = r_slot;
            w_slot_nxt   = r_slot + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Full frame = pre-edge shadow plus the word arriving now. A sync word on the
  // following edge may then overwrite shadow[0] without disturbing out_data.
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < CHANNELS - 1; k++) begin
      w_frame[k*WIDTH +: WIDTH] = r_shadow[k];
    end
    w_frame[(CHANNELS-1)*WIDTH +: WIDTH] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      for (int k = 0; k < CHANNELS - 1; k++) r_shadow[k] <= '0;
    end else begin
      r_slot      <= w_slot_nxt;
      r_out_valid <= w_load;
      r_frame_err <= w_err;
      if (w_load) r_out_data <= w_frame;
      for (int k = 0; k < CHANNELS - 1; k++) begin
        if (w_shadow_we && w_shadow_idx == SW'(k)) r_shadow[k] <= in_data;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;
  assign locked    = (r_state == ST_LOCKED);
  assign slot      = r_slot;

endmodule
